// File: rtl/idma_rd_pkg.sv
// ---------------------------------------------------------------------------
// idma_rd_pkg
// Shared types and constants for the 128b sync-read iDMA address generator.
//   gen_state_e   : walker FSM states
//   raddr_entry_t : one raddr FIFO entry {row byte address, row length in words}
//   word_align()  : clears the sub-word byte-offset bits of an address
// ---------------------------------------------------------------------------
package idma_rd_pkg;

  localparam int AXI_DATA_WID = 128;
  localparam int ROWW         = 16;
  localparam int WORD_BYTES   = AXI_DATA_WID / 8;
  localparam int ADDR_LSB     = $clog2(WORD_BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GEN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } gen_state_e;

  typedef struct packed {
    logic [31:0]     addr;
    logic [ROWW-1:0] num_word;
  } raddr_entry_t;

  // Rows are always fetched as whole bus words, so byte offsets are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:ADDR_LSB], {ADDR_LSB{1'b0}}};
  endfunction

endpackage

// File: rtl/idma_rd_addr_gen_if.sv
// ---------------------------------------------------------------------------
// idma_rd_addr_gen_if
// Descriptor, raddr FIFO and status bundle of idma_rd_addr_gen.
//   master : descriptor source / FIFO consumer (drives cfg_*, raddr_fifo_pop)
//   slave  : the address generator
// ---------------------------------------------------------------------------
interface idma_rd_addr_gen_if;
  import idma_rd_pkg::*;

  logic            cfg_valid;
  logic            cfg_ready;
  logic [31:0]     cfg_base_addr;
  logic [ROWW-1:0] cfg_row_words;
  logic [ROWW-1:0] cfg_row_num;
  logic [31:0]     cfg_row_stride;
  logic            raddr_fifo_pop;
  logic            raddr_fifo_empty;
  logic [31:0]     raddr_fifo_raddr_in;
  logic [31:0]     raddr_fifo_rd_num_word;
  logic            gen_busy;
  logic            gen_done;

  modport master (
    output cfg_valid, cfg_base_addr, cfg_row_words, cfg_row_num, cfg_row_stride,
    output raddr_fifo_pop,
    input  cfg_ready, raddr_fifo_empty, raddr_fifo_raddr_in, raddr_fifo_rd_num_word,
    input  gen_busy, gen_done
  );

  modport slave (
    input  cfg_valid, cfg_base_addr, cfg_row_words, cfg_row_num, cfg_row_stride,
    input  raddr_fifo_pop,
    output cfg_ready, raddr_fifo_empty, raddr_fifo_raddr_in, raddr_fifo_rd_num_word,
    output gen_busy, gen_done
  );

endinterface

// File: rtl/idma_sync_fifo.sv
// ---------------------------------------------------------------------------
// idma_sync_fifo
// Show-ahead synchronous FIFO; rdata_o shows the head whenever empty_o=0.
//   clk, rst_n       : clock, synchronous active-low reset (clears pointers/count)
//   push_i, wdata_i  : write request / data (ignored when full)
//   pop_i            : advance head at next edge (ignored when empty)
//   rdata_o          : head entry
//   full_o, empty_o  : status derived from the registered count
//   count_o          : number of stored entries
// ---------------------------------------------------------------------------
module idma_sync_fifo #(
  parameter  int WIDTH = 48,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  // Full is taken from the registered count, so a pop never makes room for
  // a push in the same cycle.
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/idma_rd_addr_gen.sv
// ---------------------------------------------------------------------------
// idma_rd_addr_gen
// Walks one 2D read descriptor and pushes one {row address, row words} entry
// per row into a show-ahead raddr FIFO popped by the AXI read interface.
//   aclk, aresetn : clock, synchronous active-low reset
//   bus (slave)   : cfg_* descriptor handshake, raddr_fifo_* head/pop port,
//                   gen_busy (GEN/DRAIN) and gen_done (one-cycle pulse)
// ---------------------------------------------------------------------------
module idma_rd_addr_gen
  import idma_rd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input logic               aclk,
  input logic               aresetn,
  idma_rd_addr_gen_if.slave bus
);

  localparam int EW = $bits(raddr_entry_t);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  gen_state_e      state_q, state_d;
  logic [31:0]     cur_addr_q, cur_addr_d;
  logic [31:0]     stride_q, stride_d;
  logic [ROWW-1:0] row_words_q, row_words_d;
  logic [ROWW-1:0] row_num_q, row_num_d;
  logic [ROWW-1:0] row_cnt_q, row_cnt_d;
  logic            done_q, done_d;

  logic            push;
  logic            pop_ok;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [EW-1:0]   push_vec, head_vec;
  raddr_entry_t    push_entry, head_entry;

  assign pop_ok = bus.raddr_fifo_pop && !fifo_empty;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      stride_q    <= '0;
      row_words_q <= '0;
      row_num_q   <= '0;
      row_cnt_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      stride_q    <= stride_d;
      row_words_q <= row_words_d;
      row_num_q   <= row_num_d;
      row_cnt_q   <= row_cnt_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    stride_d    = stride_q;
    row_words_d = row_words_q;
    row_num_d   = row_num_q;
    row_cnt_d   = row_cnt_q;
    done_d      = 1'b0;
    push        = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cfg_valid) begin
          cur_addr_d  = word_align(bus.cfg_base_addr);
          stride_d    = word_align(bus.cfg_row_stride);
          row_words_d = bus.cfg_row_words;
          row_num_d   = bus.cfg_row_num;
          row_cnt_d   = '0;
          // An empty descriptor skips straight to completion, pushing nothing.
          if ((bus.cfg_row_words == '0) || (bus.cfg_row_num == '0)) state_d = DONE;
          else                                                       state_d = GEN;
        end
      end
      GEN: begin
        if (!fifo_full) begin
          push       = 1'b1;
          cur_addr_d = cur_addr_q + stride_q;
          row_cnt_d  = row_cnt_q + ROWW'(1);
          if ((row_cnt_q + ROWW'(1)) == row_num_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Leave as soon as the count will be zero after this edge's pop.
        if (fifo_empty || ((fifo_count == CW'(1)) && pop_ok)) state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign push_entry = '{addr: cur_addr_q, num_word: row_words_q};
  assign push_vec   = push_entry;
  assign head_entry = raddr_entry_t'(head_vec);

  idma_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (aclk),
    .rst_n   (aresetn),
    .push_i  (push),
    .wdata_i (push_vec),
    .pop_i   (bus.raddr_fifo_pop),
    .rdata_o (head_vec),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Head fields read as zero while empty so stale storage never leaks out.
  assign bus.raddr_fifo_empty       = fifo_empty;
  assign bus.raddr_fifo_raddr_in    = fifo_empty ? 32'd0 : head_entry.addr;
  assign bus.raddr_fifo_rd_num_word = fifo_empty ? 32'd0 : 32'(head_entry.num_word);
  assign bus.cfg_ready              = aresetn && (state_q == IDLE);
  assign bus.gen_busy               = (state_q == GEN) || (state_q == DRAIN);
  // Registered: the pulse appears the cycle after the FSM passes through DONE.
  assign bus.gen_done               = done_q;

endmodule

// File: tb/tb_idma_rd_addr_gen.sv
// ---------------------------------------------------------------------------
// tb_idma_rd_addr_gen
// Directed, table-driven bench for idma_rd_addr_gen plus hand-written
// sequences for reset, exact completion latency and zero-size descriptors.
// ---------------------------------------------------------------------------
module tb_idma_rd_addr_gen;
  import idma_rd_pkg::*;

  localparam int FIFO_DEPTH = 4;

  logic aclk = 1'b0;
  logic aresetn;

  idma_rd_addr_gen_if bus ();

  idma_rd_addr_gen #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] base;
    logic [15:0] words;
    logic [15:0] rows;
    logic [31:0] stride;
    int          hold;      // cycles with no pops after accept
    int          period;    // pop every Nth cycle afterwards
    bit          junk;      // drive cfg_valid with other fields while busy
    int          exp_n;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } desc_t;

  desc_t vec [7];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive_cfg(input logic v, input logic [31:0] b, input logic [15:0] w,
                           input logic [15:0] r, input logic [31:0] s);
    bus.cfg_valid      = v;
    bus.cfg_base_addr  = b;
    bus.cfg_row_words  = w;
    bus.cfg_row_num    = r;
    bus.cfg_row_stride = s;
  endtask

  task automatic run_desc(input int id, input desc_t d);
    int          cyc, popped, dones;
    bit          pop_en;
    logic [31:0] exp_a, first_a, last_a;
    cyc = 0; popped = 0; dones = 0; first_a = '0; last_a = '0;
    chk($sformatf("d%0d ready_before", id), 32'(bus.cfg_ready), 32'd1);
    drive_cfg(1'b1, d.base, d.words, d.rows, d.stride);
    step();
    while (dones == 0 && cyc < 400) begin
      if (d.junk) drive_cfg(bus.gen_busy, 32'hDEAD_BEE0, 16'd3, 16'd1, 32'h1230);
      else        bus.cfg_valid = 1'b0;
      if (d.hold > 0 && cyc == d.hold)
        chk($sformatf("d%0d count_saturated", id), 32'(dut.u_fifo.count_q), FIFO_DEPTH);
      pop_en = (cyc >= d.hold) && (((cyc - d.hold) % d.period) == 0);
      bus.raddr_fifo_pop = pop_en;
      if (pop_en && !bus.raddr_fifo_empty) begin
        exp_a = (d.base & 32'hFFFF_FFF0) + 32'(popped) * (d.stride & 32'hFFFF_FFF0);
        chk($sformatf("d%0d e%0d addr", id, popped), bus.raddr_fifo_raddr_in, exp_a);
        chk($sformatf("d%0d e%0d words", id, popped), bus.raddr_fifo_rd_num_word, 32'(d.words));
        if (popped == 0) first_a = bus.raddr_fifo_raddr_in;
        last_a = bus.raddr_fifo_raddr_in;
        popped++;
      end
      if (bus.gen_done) dones++;
      step();
      cyc++;
    end
    bus.raddr_fifo_pop = 1'b0;
    bus.cfg_valid      = 1'b0;
    chk($sformatf("d%0d done_seen", id), 32'(dones), 32'd1);
    chk($sformatf("d%0d entry_count", id), 32'(popped), 32'(d.exp_n));
    if (d.exp_n > 0) begin
      chk($sformatf("d%0d first_addr", id), first_a, d.exp_first);
      chk($sformatf("d%0d last_addr", id), last_a, d.exp_last);
    end
    chk($sformatf("d%0d done_one_cycle", id), 32'(bus.gen_done), 32'd0);
    chk($sformatf("d%0d ready_after", id), 32'(bus.cfg_ready), 32'd1);
    chk($sformatf("d%0d empty_after", id), 32'(bus.raddr_fifo_empty), 32'd1);
    $display("desc %0d: base=0x%08h words=%0d rows=%0d stride=0x%08h -> %0d entries in %0d cycles",
             id, d.base, d.words, d.rows, d.stride, popped, cyc);
  endtask

  initial begin
    int dones;
    vec[0] = '{32'h0000_1000, 16'd8,      16'd1,  32'h0000_0000, 0,  1, 1'b0, 1,  32'h0000_1000, 32'h0000_1000};
    vec[1] = '{32'h0000_2000, 16'd4,      16'd6,  32'h0000_0100, 0,  1, 1'b0, 6,  32'h0000_2000, 32'h0000_2500};
    vec[2] = '{32'h0000_4000, 16'd2,      16'd10, 32'h0000_0040, 20, 3, 1'b0, 10, 32'h0000_4000, 32'h0000_4240};
    vec[3] = '{32'hFFFF_FF0F, 16'd1,      16'd3,  32'h0000_0080, 0,  1, 1'b0, 3,  32'hFFFF_FF00, 32'h0000_0000};
    vec[4] = '{32'h0000_5000, 16'd5,      16'd0,  32'h0000_0010, 0,  1, 1'b0, 0,  32'h0,         32'h0};
    vec[5] = '{32'h0000_3000, 16'd7,      16'd3,  32'h0000_0040, 0,  2, 1'b1, 3,  32'h0000_3000, 32'h0000_3080};
    vec[6] = '{32'h0000_6008, 16'hFFFF,   16'd2,  32'h0000_0013, 0,  1, 1'b0, 2,  32'h0000_6000, 32'h0000_6010};

    // Reset state
    aresetn = 1'b0;
    bus.raddr_fifo_pop = 1'b0;
    drive_cfg(1'b0, '0, '0, '0, '0);
    step(); step(); step();
    chk("rst cfg_ready", 32'(bus.cfg_ready), 32'd0);
    chk("rst empty", 32'(bus.raddr_fifo_empty), 32'd1);
    chk("rst busy", 32'(bus.gen_busy), 32'd0);
    chk("rst done", 32'(bus.gen_done), 32'd0);
    chk("rst head_addr", bus.raddr_fifo_raddr_in, 32'd0);
    chk("rst head_words", bus.raddr_fifo_rd_num_word, 32'd0);
    aresetn = 1'b1;
    step();
    chk("post_rst cfg_ready", 32'(bus.cfg_ready), 32'd1);

    // Pop on empty is ignored
    bus.raddr_fifo_pop = 1'b1;
    step(); step();
    bus.raddr_fifo_pop = 1'b0;
    chk("pop_empty count", 32'(dut.u_fifo.count_q), 32'd0);
    chk("pop_empty empty", 32'(bus.raddr_fifo_empty), 32'd1);

    // Single row, exact latency
    drive_cfg(1'b1, 32'h1000, 16'd8, 16'd1, 32'h0);
    step();
    bus.cfg_valid = 1'b0;
    chk("single empty_c1", 32'(bus.raddr_fifo_empty), 32'd1);
    chk("single busy_c1", 32'(bus.gen_busy), 32'd1);
    chk("single ready_c1", 32'(bus.cfg_ready), 32'd0);
    step();
    chk("single empty_c2", 32'(bus.raddr_fifo_empty), 32'd0);
    chk("single addr", bus.raddr_fifo_raddr_in, 32'h1000);
    chk("single words", bus.raddr_fifo_rd_num_word, 32'd8);
    bus.raddr_fifo_pop = 1'b1;
    step();
    bus.raddr_fifo_pop = 1'b0;
    chk("single empty_c3", 32'(bus.raddr_fifo_empty), 32'd1);
    chk("single done_c3", 32'(bus.gen_done), 32'd0);
    step();
    chk("single done_c4", 32'(bus.gen_done), 32'd1);
    chk("single ready_c4", 32'(bus.cfg_ready), 32'd1);
    step();
    chk("single done_c5", 32'(bus.gen_done), 32'd0);
    $display("hand single-row: done pulse checked");

    // Zero words: done exactly 2 cycles after accept edge
    drive_cfg(1'b1, 32'h8000, 16'd0, 16'd4, 32'h10);
    step();
    bus.cfg_valid = 1'b0;
    chk("zero done_c1", 32'(bus.gen_done), 32'd0);
    chk("zero empty_c1", 32'(bus.raddr_fifo_empty), 32'd1);
    step();
    chk("zero done_c2", 32'(bus.gen_done), 32'd1);
    chk("zero empty_c2", 32'(bus.raddr_fifo_empty), 32'd1);
    step();
    chk("zero done_c3", 32'(bus.gen_done), 32'd0);
    $display("hand zero-words: done timing checked");

    // Table-driven descriptors
    for (int i = 0; i < 7; i++) run_desc(i, vec[i]);

    // Mid-run reset after two entries
    drive_cfg(1'b1, 32'h7000, 16'd3, 16'd8, 32'h20);
    step();
    bus.cfg_valid = 1'b0;
    step(); step();
    chk("midrst count_before", 32'(dut.u_fifo.count_q), 32'd2);
    aresetn = 1'b0;
    #1;
    chk("midrst cfg_ready_low", 32'(bus.cfg_ready), 32'd0);
    step();
    chk("midrst empty", 32'(bus.raddr_fifo_empty), 32'd1);
    chk("midrst busy", 32'(bus.gen_busy), 32'd0);
    chk("midrst done", 32'(bus.gen_done), 32'd0);
    chk("midrst head", bus.raddr_fifo_raddr_in, 32'd0);
    aresetn = 1'b1;
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus.gen_done) dones++;
    end
    chk("midrst no_done", 32'(dones), 32'd0);
    $display("hand mid-run reset: state cleared");
    run_desc(7, vec[1]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
